// File: rtl/divmul_pkg.sv
// Shared definitions for the divider / shift-add multiplier pair:
// FLAG codes, FSM state encoding and datapath widths.
package divmul_pkg;

    localparam int QW = 16;
    localparam int BW = 8;
    localparam int AW = 24;

    localparam logic [2:0] FLAG_OK     = 3'b000;
    localparam logic [2:0] FLAG_OVF    = 3'b001;
    localparam logic [2:0] FLAG_DIV0   = 3'b011;
    localparam logic [2:0] FLAG_ONE    = 3'b100;
    localparam logic [2:0] FLAG_POW2   = 3'b101;
    localparam logic [2:0] FLAG_BADREM = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle between the requester and the shift-add multiplier.
interface shift_add_multiplier_if;
    import divmul_pkg::*;

    logic          LOAD;
    logic [QW-1:0] inQ;
    logic [BW-1:0] inB;
    logic [BW-1:0] inR;
    logic [QW-1:0] prod;
    logic [2:0]    FLAG;
    logic          BUSY;
    logic          DONE;

    modport master (
        output LOAD, inQ, inB, inR,
        input  prod, FLAG, BUSY, DONE
    );

    modport slave (
        input  LOAD, inQ, inB, inR,
        output prod, FLAG, BUSY, DONE
    );

endinterface

// File: rtl/mul_flag_encode.sv
// Priority encoder classifying a reconstructed product; first match wins.
module mul_flag_encode
    import divmul_pkg::*;
(
    input  logic [BW-1:0]    b,
    input  logic [BW-1:0]    r,
    input  logic [AW-QW-1:0] acc_hi,
    output logic [2:0]       flag
);

    always_comb begin
        flag = FLAG_OK;
        if (b == '0) begin
            flag = FLAG_DIV0;
        end else if (r >= b) begin
            flag = FLAG_BADREM;
        end else if (acc_hi != '0) begin
            flag = FLAG_OVF;
        end else if (b == BW'(1)) begin
            flag = FLAG_ONE;
        end else if ((b & (b - BW'(1))) == '0) begin
            flag = FLAG_POW2;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential multiplier reconstructing a dividend as inQ*inB+inR,
// consuming one divisor bit per clock (divisors 0 and 1 take a one-cycle shortcut).
module shift_add_multiplier
    import divmul_pkg::*;
(
    input logic                  CLOCK,
    input logic                  RESET,
    shift_add_multiplier_if.slave bus
);

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    qsh_q, qsh_d;
    logic [BW-1:0]    bsh_q, bsh_d;
    logic [BW-1:0]    rq_q, rq_d;
    logic [BW-1:0]    rb_q, rb_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [QW-1:0]    prod_q, prod_d;
    logic [2:0]       flag_q, flag_d;

    logic             accept;
    logic             fast;
    logic [AW-1:0]    acc_step;
    logic [AW-1:0]    fast_acc;
    logic [BW-1:0]    enc_b, enc_r;
    logic [AW-QW-1:0] enc_hi;
    logic [2:0]       flag_enc;

    assign accept   = bus.LOAD && (state_q != ST_CALC);
    assign fast     = (bus.inB <= BW'(1));
    assign acc_step = acc_q + (bsh_q[0] ? qsh_q : '0);
    assign fast_acc = (bus.inB == '0) ? AW'(bus.inR) : (AW'(bus.inQ) + AW'(bus.inR));

    // Outside CALC the encoder sees the operands being accepted (fast path),
    // inside CALC it sees the latched operands and the final accumulator.
    always_comb begin
        enc_b  = rb_q;
        enc_r  = rq_q;
        enc_hi = acc_step[AW-1:QW];
        if (state_q != ST_CALC) begin
            enc_b  = bus.inB;
            enc_r  = bus.inR;
            enc_hi = fast_acc[AW-1:QW];
        end
    end

    mul_flag_encode u_flag (
        .b      (enc_b),
        .r      (enc_r),
        .acc_hi (enc_hi),
        .flag   (flag_enc)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (accept) begin
                    state_d = fast ? ST_FIN : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == 3'd7) begin
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY = (state_q == ST_CALC);
        bus.DONE = (state_q == ST_FIN);
        bus.prod = prod_q;
        bus.FLAG = flag_q;
    end

    always_comb begin
        acc_d  = acc_q;
        qsh_d  = qsh_q;
        bsh_d  = bsh_q;
        rq_d   = rq_q;
        rb_d   = rb_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        flag_d = flag_q;
        if (accept) begin
            qsh_d = {{(AW-QW){1'b0}}, bus.inQ};
            bsh_d = bus.inB;
            rq_d  = bus.inR;
            rb_d  = bus.inB;
            cnt_d = '0;
            acc_d = fast ? fast_acc : AW'(bus.inR);
            if (fast) begin
                prod_d = fast_acc[QW-1:0];
                flag_d = flag_enc;
            end
        end else if (state_q == ST_CALC) begin
            acc_d = acc_step;
            qsh_d = qsh_q << 1;
            bsh_d = bsh_q >> 1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                prod_d = acc_step[QW-1:0];
                flag_d = flag_enc;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            acc_q  <= '0;
            qsh_q  <= '0;
            bsh_q  <= '0;
            rq_q   <= '0;
            rb_q   <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            flag_q <= FLAG_OK;
        end else begin
            acc_q  <= acc_d;
            qsh_q  <= qsh_d;
            bsh_q  <= bsh_d;
            rq_q   <= rq_d;
            rb_q   <= rb_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_add_multiplier;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    shift_add_multiplier_if bus ();

    shift_add_multiplier dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision arithmetic, then classification by priority.
    function automatic void model(input logic [15:0] q, input logic [7:0] b,
                                  input logic [7:0] r,
                                  output logic [15:0] p, output logic [2:0] f);
        int unsigned full;
        full = int'(q) * int'(b) + int'(r);
        p = full[15:0];
        if (b == 8'd0)                 f = 3'b011;
        else if (r >= b)               f = 3'b111;
        else if (full > 32'd65535)     f = 3'b001;
        else if (b == 8'd1)            f = 3'b100;
        else if ($countones(b) == 1)   f = 3'b101;
        else                           f = 3'b000;
    endfunction

    // Present operands with LOAD for one edge, then scramble the inputs;
    // returns at the falling edge right after the accept edge.
    task automatic start_op(input logic [15:0] q, input logic [7:0] b, input logic [7:0] r);
        @(negedge clk);
        bus.inQ  = q;
        bus.inB  = b;
        bus.inR  = r;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        bus.inQ  = 16'($urandom);
        bus.inB  = 8'($urandom);
        bus.inR  = 8'($urandom);
    endtask

    // k = number of edges after the accept edge at which DONE is seen.
    task automatic wait_done(output int k, output int busy_cnt);
        k = 0;
        busy_cnt = 0;
        while (!bus.DONE && k < 20) begin
            if (bus.BUSY) busy_cnt++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.LOAD = 1'b0;
        bus.inQ = '0;
        bus.inB = '0;
        bus.inR = '0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({bus.prod, bus.FLAG, bus.BUSY, bus.DONE} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got prod=%h flag=%b busy=%b done=%b, want all zero",
                     bus.prod, bus.FLAG, bus.BUSY, bus.DONE);
        end
        rst = 1'b0;
    endtask

    task automatic test_general();
        int k, bc;
        start_op(16'd1000, 8'd7, 8'd3);
        wait_done(k, bc);
        n_run++;
        if (k !== 8 || bc !== 8) begin
            n_fail++;
            $display("FAIL general_timing: got latency=%0d busy=%0d, want 8/8", k, bc);
        end
        n_run++;
        if (bus.prod !== 16'h1B5B || bus.FLAG !== 3'b000) begin
            n_fail++;
            $display("FAIL general_result: got prod=%h flag=%b, want 1b5b/000", bus.prod, bus.FLAG);
        end
        @(negedge clk);
        n_run++;
        if (bus.DONE !== 1'b0 || bus.prod !== 16'h1B5B) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b prod=%h, want 0/1b5b", bus.DONE, bus.prod);
        end
    endtask

    task automatic test_fast_path();
        int k, bc;
        start_op(16'h1234, 8'd1, 8'd0);
        wait_done(k, bc);
        n_run++;
        if (k !== 0 || bc !== 0 || bus.prod !== 16'h1234 || bus.FLAG !== 3'b100) begin
            n_fail++;
            $display("FAIL fast_one: got lat=%0d busy=%0d prod=%h flag=%b, want 0/0/1234/100",
                     k, bc, bus.prod, bus.FLAG);
        end
        start_op(16'hFFFF, 8'd0, 8'd5);
        wait_done(k, bc);
        n_run++;
        if (k !== 0 || bc !== 0 || bus.prod !== 16'h0005 || bus.FLAG !== 3'b011) begin
            n_fail++;
            $display("FAIL fast_zero: got lat=%0d busy=%0d prod=%h flag=%b, want 0/0/0005/011",
                     k, bc, bus.prod, bus.FLAG);
        end
    endtask

    task automatic test_flag_priority();
        int k, bc;
        start_op(16'h8000, 8'd4, 8'd1);
        wait_done(k, bc);
        n_run++;
        if (k !== 8 || bus.prod !== 16'h0001 || bus.FLAG !== 3'b001) begin
            n_fail++;
            $display("FAIL overflow_flag: got lat=%0d prod=%h flag=%b, want 8/0001/001",
                     k, bus.prod, bus.FLAG);
        end
        start_op(16'd10, 8'd3, 8'd5);
        wait_done(k, bc);
        n_run++;
        if (k !== 8 || bus.prod !== 16'd35 || bus.FLAG !== 3'b111) begin
            n_fail++;
            $display("FAIL badrem_flag: got lat=%0d prod=%0d flag=%b, want 8/35/111",
                     k, bus.prod, bus.FLAG);
        end
    endtask

    task automatic test_back_to_back();
        int k, bc;
        start_op(16'd100, 8'd9, 8'd0);
        @(negedge clk);
        @(negedge clk);
        bus.LOAD = 1'b1;
        bus.inQ  = 16'd7;
        bus.inB  = 8'd2;
        bus.inR  = 8'd1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        wait_done(k, bc);
        n_run++;
        if (k + 3 !== 8 || bus.prod !== 16'd900 || bus.FLAG !== 3'b000) begin
            n_fail++;
            $display("FAIL ignore_load: got lat=%0d prod=%0d flag=%b, want 8/900/000",
                     k + 3, bus.prod, bus.FLAG);
        end
        bus.LOAD = 1'b1;
        bus.inQ  = 16'd300;
        bus.inB  = 8'd5;
        bus.inR  = 8'd2;
        @(negedge clk);
        bus.LOAD = 1'b0;
        n_run++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 || bus.prod !== 16'd900) begin
            n_fail++;
            $display("FAIL fin_accept: got busy=%b done=%b prod=%0d, want 1/0/900",
                     bus.BUSY, bus.DONE, bus.prod);
        end
        wait_done(k, bc);
        n_run++;
        if (k !== 8 || bus.prod !== 16'd1502 || bus.FLAG !== 3'b000) begin
            n_fail++;
            $display("FAIL back_to_back: got lat=%0d prod=%0d flag=%b, want 8/1502/000",
                     k, bus.prod, bus.FLAG);
        end
    endtask

    task automatic test_random();
        logic [15:0] q, ep;
        logic [7:0]  b, r;
        logic [2:0]  ef;
        int          sel, k, bc, ek;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            q = 16'($urandom);
            if (sel == 0)      b = 8'd0;
            else if (sel == 1) b = 8'd1;
            else if (sel == 2) b = 8'd1 << $urandom_range(1, 7);
            else               b = 8'($urandom);
            if (b != 8'd0 && $urandom_range(0, 9) < 7) r = 8'($urandom_range(0, int'(b) - 1));
            else                                      r = 8'($urandom);
            model(q, b, r, ep, ef);
            ek = (b <= 8'd1) ? 0 : 8;
            start_op(q, b, r);
            wait_done(k, bc);
            n_run++;
            if (k !== ek || bc !== ek || bus.prod !== ep || bus.FLAG !== ef) begin
                n_fail++;
                $display("FAIL random_op%0d q=%h b=%h r=%h: got lat=%0d busy=%0d prod=%h flag=%b, want %0d/%0d/%h/%b",
                         i, q, b, r, k, bc, bus.prod, bus.FLAG, ek, ek, ep, ef);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        start_op(16'd1000, 8'd7, 8'd3);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if ({bus.prod, bus.FLAG, bus.BUSY, bus.DONE} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_abort_state: got prod=%h flag=%b busy=%b done=%b, want all zero",
                     bus.prod, bus.FLAG, bus.BUSY, bus.DONE);
        end
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.DONE || bus.BUSY) seen++;
        end
        n_run++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_quiet: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_reset_load_same_edge();
        int seen;
        @(negedge clk);
        rst      = 1'b1;
        bus.LOAD = 1'b1;
        bus.inQ  = 16'd50;
        bus.inB  = 8'd1;
        bus.inR  = 8'd0;
        @(negedge clk);
        rst      = 1'b0;
        bus.LOAD = 1'b0;
        seen = 0;
        repeat (10) begin
            if (bus.DONE || bus.BUSY || bus.prod != 16'd0) seen++;
            @(negedge clk);
        end
        n_run++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_beats_load: got %0d active cycles, want 0", seen);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset();
        test_general();
        test_fast_path();
        test_flag_priority();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_general();
        test_reset_load_same_edge();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
